// File: rtl/int_pkg.sv
// Shared definitions for the external interrupt source: debounce states,
// line indices and the mapping of lines onto CAUSE IP bits.
package int_pkg;

  typedef enum logic [1:0] {
    LOW,
    RISE_WAIT,
    HIGH,
    FALL_WAIT
  } db_state_t;

  localparam int INT_TIMER     = 0;
  localparam int INT_BTN       = 1;
  localparam int CAUSE_IP_BASE = 6;

  // Line i is observed by software as CAUSE.IP(6+i).
  function automatic int cause_ip_bit(input int line);
    return CAUSE_IP_BASE + line;
  endfunction

endpackage

// File: rtl/debounce.sv
// Two-flop synchronizer followed by a four-state debounce FSM; emits a
// registered one-cycle pulse when the debounced level rises.
module debounce
  import int_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic rise_evt
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic            sync_p0;
  logic            btn_s;
  db_state_t       state;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_p0  <= 1'b0;
      btn_s    <= 1'b0;
      state    <= LOW;
      cnt      <= '0;
      rise_evt <= 1'b0;
    end else begin
      sync_p0  <= raw;
      btn_s    <= sync_p0;
      rise_evt <= 1'b0;
      case (state)
        LOW: begin
          if (btn_s) begin
            state <= RISE_WAIT;
            cnt   <= CNT_ONE;
          end
        end
        RISE_WAIT: begin
          if (!btn_s) begin
            state <= LOW;
          end else if (cnt == CNT_MAX) begin
            state    <= HIGH;
            rise_evt <= 1'b1;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        HIGH: begin
          if (!btn_s) begin
            state <= FALL_WAIT;
            cnt   <= CNT_ONE;
          end
        end
        FALL_WAIT: begin
          if (btn_s) begin
            state <= HIGH;
          end else if (cnt == CNT_MAX) begin
            state <= LOW;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        default: state <= LOW;
      endcase
    end
  end

  assign level = (state == HIGH) || (state == FALL_WAIT);

endmodule

// File: rtl/int_source.sv
// External interrupt source: periodic timer plus debounced button, each held
// as a level request with a sticky overrun flag until acknowledged.
module int_source
  import int_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int TIMER_WIDTH     = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   btn_raw,
  input  logic                   timer_en,
  input  logic [TIMER_WIDTH-1:0] timer_period,
  input  logic [1:0]             int_ack,
  output logic [1:0]             interrupt,
  output logic [1:0]             overrun
);

  localparam logic [TIMER_WIDTH-1:0] TMR_ONE = TIMER_WIDTH'(1);

  logic                   btn_level;
  logic                   btn_evt;
  logic [TIMER_WIDTH-1:0] count;
  logic                   tmr_evt;
  logic [1:0]             evt;

  debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_btn_debounce (
    .clk     (clk),
    .rst     (rst),
    .raw     (btn_raw),
    .level   (btn_level),
    .rise_evt(btn_evt)
  );

  // Timer stage: >= compare lets a period lowered mid-count fire immediately.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count   <= '0;
      tmr_evt <= 1'b0;
    end else begin
      tmr_evt <= 1'b0;
      if (!timer_en || (timer_period == '0)) begin
        count <= '0;
      end else if (count >= timer_period - TMR_ONE) begin
        count   <= '0;
        tmr_evt <= 1'b1;
      end else begin
        count <= count + TMR_ONE;
      end
    end
  end

  // rise_evt only ever asserts while the debounced level is high.
  always_comb begin
    evt            = 2'b00;
    evt[INT_TIMER] = tmr_evt;
    evt[INT_BTN]   = btn_evt & btn_level;
  end

  // Pending stage: a new event beats a same-cycle acknowledge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      interrupt <= 2'b00;
      overrun   <= 2'b00;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (evt[i]) begin
          interrupt[i] <= 1'b1;
          if (int_ack[i]) begin
            overrun[i] <= 1'b0;
          end else if (interrupt[i]) begin
            overrun[i] <= 1'b1;
          end
        end else if (int_ack[i]) begin
          interrupt[i] <= 1'b0;
          overrun[i]   <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_int_source.sv
// Directed bench for int_source with DEBOUNCE_CYCLES=4 and a 16-bit timer.
module tb_int_source;

  localparam int DB = 4;
  localparam int TW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          btn_raw;
  logic          timer_en;
  logic [TW-1:0] timer_period;
  logic [1:0]    int_ack;
  logic [1:0]    interrupt;
  logic [1:0]    overrun;

  int n_checks = 0;
  int n_pass   = 0;

  int_source #(
    .DEBOUNCE_CYCLES(DB),
    .TIMER_WIDTH    (TW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .btn_raw     (btn_raw),
    .timer_en    (timer_en),
    .timer_period(timer_period),
    .int_ack     (int_ack),
    .interrupt   (interrupt),
    .overrun     (overrun)
  );

  always #5 clk = ~clk;

  // Advance past one rising edge; inputs set afterwards are sampled next edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; btn_raw = 1'b1; timer_en = 1'b1; timer_period = '0; int_ack = 2'b00;
    repeat (3) step();
    n_checks++;
    if (interrupt !== 2'b00 || overrun !== 2'b00)
      $display("FAIL reset_held: interrupt=%b overrun=%b, required 00/00", interrupt, overrun);
    else n_pass++;
    rst = 1'b1;
    n_checks++;
    if (interrupt !== 2'b00 || overrun !== 2'b00)
      $display("FAIL reset_release: interrupt=%b overrun=%b, required 00/00", interrupt, overrun);
    else n_pass++;
    for (int e = 0; e <= 7; e++) begin
      step();
      if (e == 6) begin
        n_checks++;
        if (interrupt[1] !== 1'b0) $display("FAIL reset_btn_early: interrupt[1]=%b at edge 6, required 0", interrupt[1]);
        else n_pass++;
      end
      if (e == 7) begin
        n_checks++;
        if (interrupt[1] !== 1'b1) $display("FAIL reset_btn_rise: interrupt[1]=%b at edge 7, required 1", interrupt[1]);
        else n_pass++;
      end
    end
    int_ack = 2'b10;
    step();
    int_ack = 2'b00;
    n_checks++;
    if (interrupt !== 2'b00) $display("FAIL btn_ack: interrupt=%b, required 00", interrupt);
    else n_pass++;
  endtask

  task automatic test_debounce();
    int rises;
    int rise_edge;
    logic prev;
    btn_raw = 1'b0;
    rises = 0;
    repeat (12) begin
      step();
      if (interrupt[1]) rises++;
    end
    n_checks++;
    if (rises !== 0) $display("FAIL falling_edge_no_event: rise cycles=%0d, required 0", rises);
    else n_pass++;

    btn_raw = 1'b1;
    repeat (3) step();
    btn_raw = 1'b0;
    rises = 0;
    repeat (12) begin
      step();
      if (interrupt[1]) rises++;
    end
    n_checks++;
    if (rises !== 0) $display("FAIL glitch_3_cycles: interrupt[1] high cycles=%0d, required 0", rises);
    else n_pass++;

    btn_raw = 1'b1;
    rises = 0;
    rise_edge = -1;
    prev = interrupt[1];
    for (int e = 0; e < 20; e++) begin
      step();
      if (interrupt[1] && !prev) begin
        rises++;
        rise_edge = e;
      end
      prev = interrupt[1];
      if (e == 9) btn_raw = 1'b0;
    end
    n_checks++;
    if (rises !== 1) $display("FAIL hold_rise_count: rises=%0d, required 1", rises);
    else n_pass++;
    n_checks++;
    if (rise_edge !== 7) $display("FAIL hold_rise_edge: rise at edge %0d, required 7", rise_edge);
    else n_pass++;
    int_ack = 2'b10;
    step();
    int_ack = 2'b00;
    repeat (4) step();
    n_checks++;
    if (interrupt[1] !== 1'b0) $display("FAIL hold_ack: interrupt[1]=%b, required 0", interrupt[1]);
    else n_pass++;
  endtask

  task automatic test_timer();
    int rises;
    int rise_edges[3];
    logic prev;
    logic ovr_seen;
    int high_cnt;
    timer_en = 1'b0;
    step();
    timer_period = 16'd5;
    timer_en = 1'b1;
    rises = 0;
    rise_edges = '{-1, -1, -1};
    prev = 1'b0;
    ovr_seen = 1'b0;
    for (int e = 0; e <= 16; e++) begin
      step();
      int_ack = 2'b00;
      if (interrupt[0] && !prev) begin
        if (rises < 3) rise_edges[rises] = e;
        rises++;
        int_ack = 2'b01;
      end
      if (overrun[0]) ovr_seen = 1'b1;
      prev = interrupt[0];
    end
    int_ack = 2'b00;
    n_checks++;
    if (rises !== 3) $display("FAIL timer_rise_count: rises=%0d, required 3", rises);
    else n_pass++;
    n_checks++;
    if (rise_edges[0] !== 5 || rise_edges[1] !== 10 || rise_edges[2] !== 15)
      $display("FAIL timer_rise_edges: got %0d,%0d,%0d required 5,10,15",
               rise_edges[0], rise_edges[1], rise_edges[2]);
    else n_pass++;
    n_checks++;
    if (ovr_seen !== 1'b0) $display("FAIL timer_no_overrun: overrun[0] seen=%b, required 0", ovr_seen);
    else n_pass++;

    timer_en = 1'b0;
    step();
    timer_period = '0;
    timer_en = 1'b1;
    high_cnt = 0;
    repeat (20) begin
      step();
      if (interrupt[0]) high_cnt++;
    end
    n_checks++;
    if (high_cnt !== 0) $display("FAIL timer_period0: interrupt[0] high cycles=%0d, required 0", high_cnt);
    else n_pass++;
    timer_en = 1'b0;
    step();
  endtask

  // Leaves the timer running with period 3 at edge 7 for test_simultaneous.
  task automatic test_overrun();
    timer_period = 16'd3;
    timer_en = 1'b1;
    for (int e = 0; e <= 6; e++) begin
      step();
      if (e == 2) begin
        n_checks++;
        if (interrupt[0] !== 1'b0) $display("FAIL ovr_early: interrupt[0]=%b at edge 2, required 0", interrupt[0]);
        else n_pass++;
      end
      if (e == 3) begin
        n_checks++;
        if (interrupt[0] !== 1'b1 || overrun[0] !== 1'b0)
          $display("FAIL ovr_first: interrupt[0]=%b overrun[0]=%b at edge 3, required 1/0", interrupt[0], overrun[0]);
        else n_pass++;
      end
      if (e == 6) begin
        n_checks++;
        if (overrun[0] !== 1'b1) $display("FAIL ovr_set: overrun[0]=%b at edge 6, required 1", overrun[0]);
        else n_pass++;
      end
    end
    int_ack = 2'b01;
    step();
    int_ack = 2'b00;
    n_checks++;
    if (interrupt[0] !== 1'b0 || overrun[0] !== 1'b0)
      $display("FAIL ovr_ack: interrupt[0]=%b overrun[0]=%b, required 0/0", interrupt[0], overrun[0]);
    else n_pass++;
  endtask

  task automatic test_simultaneous();
    for (int e = 8; e <= 14; e++) begin
      step();
      if (e == 12) begin
        n_checks++;
        if (overrun[0] !== 1'b1) $display("FAIL simul_setup: overrun[0]=%b at edge 12, required 1", overrun[0]);
        else n_pass++;
      end
    end
    int_ack = 2'b01;
    step();
    int_ack = 2'b00;
    n_checks++;
    if (interrupt[0] !== 1'b1 || overrun[0] !== 1'b0)
      $display("FAIL simul_evt_ack: interrupt[0]=%b overrun[0]=%b, required 1/0", interrupt[0], overrun[0]);
    else n_pass++;
    timer_en = 1'b0;
    int_ack = 2'b01;
    step();
    int_ack = 2'b00;
    n_checks++;
    if (interrupt[0] !== 1'b0) $display("FAIL simul_cleanup: interrupt[0]=%b, required 0", interrupt[0]);
    else n_pass++;
  endtask

  task automatic test_period_change();
    timer_period = 16'd10;
    timer_en = 1'b1;
    repeat (7) step();
    timer_period = 16'd4;
    for (int e = 7; e <= 12; e++) begin
      step();
      int_ack = 2'b00;
      if (e == 7 || e == 9 || e == 11) begin
        n_checks++;
        if (interrupt[0] !== 1'b0) $display("FAIL period_chg_low_e%0d: interrupt[0]=%b, required 0", e, interrupt[0]);
        else n_pass++;
      end
      if (e == 8 || e == 12) begin
        n_checks++;
        if (interrupt[0] !== 1'b1) $display("FAIL period_chg_high_e%0d: interrupt[0]=%b, required 1", e, interrupt[0]);
        else n_pass++;
      end
      if (e == 8) int_ack = 2'b01;
    end
    timer_en = 1'b0;
    int_ack = 2'b01;
    step();
    int_ack = 2'b00;
  endtask

  task automatic test_reset_mid();
    int high_cnt;
    timer_period = 16'd2;
    timer_en = 1'b1;
    btn_raw = 1'b1;
    repeat (5) step();
    n_checks++;
    if (interrupt !== 2'b01) $display("FAIL mid_setup: interrupt=%b, required 01", interrupt);
    else n_pass++;
    rst = 1'b0;
    #1;
    n_checks++;
    if (interrupt !== 2'b00 || overrun !== 2'b00)
      $display("FAIL mid_async_clear: interrupt=%b overrun=%b, required 00/00", interrupt, overrun);
    else n_pass++;
    btn_raw = 1'b0;
    timer_en = 1'b0;
    repeat (2) step();
    rst = 1'b1;
    high_cnt = 0;
    repeat (12) begin
      step();
      if (interrupt !== 2'b00) high_cnt++;
    end
    n_checks++;
    if (high_cnt !== 0) $display("FAIL mid_no_event: nonzero interrupt cycles=%0d, required 0", high_cnt);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_debounce();
    test_timer();
    test_overrun();
    test_simultaneous();
    test_period_change();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/int_source.md
# int_source

External interrupt source feeding the CPU's two-bit `interrupt` input (CAUSE IP7..IP6 in the CP0 block). It generates a periodic timer request and a debounced push-button request, and holds each as a level until the exception handler acknowledges it. It sits beside the pipeline top and drives the level interrupt lines that CP0 samples in WB.

## Interface

Parameters:
- `DEBOUNCE_CYCLES`, 16: number of consecutive stable synchronized samples before the button level changes; must be ≥ 1.
- `TIMER_WIDTH`, 16: width of the timer counter and of `timer_period`.

Ports:
- `clk`  in  1  system clock, the same divided `clk` as the pipeline.
- `rst`  in  1  asynchronous, active-low reset.
- `btn_raw`  in  1  raw, unsynchronized push-button level, active high.
- `timer_en`  in  1  timer run enable.
- `timer_period`  in  TIMER_WIDTH  timer period in cycles; 0 disables timer events.
- `int_ack`  in  2  one-cycle acknowledge per line from the handler; bit i clears line i.
- `interrupt`  out  2  registered level requests. Bit 0 is the timer, bit 1 is the button.
- `overrun`  out  2  sticky flag per line: an event arrived while that line was already pending.

## Operation

- Reset (`rst`=0) clears everything: `interrupt`=2'b00, `overrun`=2'b00, timer count 0, synchronizer flops 0, debounce state LOW, debounce counter 0.
- Synchronizer: 2-flop chain on `btn_raw` produces `btn_s`.
- Debounce FSM, with states LOW, RISE_WAIT, HIGH and FALL_WAIT:
  - LOW: if `btn_s`=1, go to RISE_WAIT with cnt=1.
  - RISE_WAIT: if `btn_s`=0, go to LOW. Else if cnt==DEBOUNCE_CYCLES, go to HIGH and emit `btn_evt` for one cycle. Else cnt+1.
  - HIGH: if `btn_s`=0, go to FALL_WAIT with cnt=1.
  - FALL_WAIT: if `btn_s`=1, go to HIGH. Else if cnt==DEBOUNCE_CYCLES, go to LOW. Else cnt+1.
  - Only the rising edge produces an event. The counter is ceil(log2(DEBOUNCE_CYCLES+1)) bits wide.
- Timer:
  - If `timer_en`=0 or `timer_period`=0, count is forced to 0 and there is no event.
  - Otherwise, if count ≥ `timer_period`-1, count becomes 0 and `tmr_evt` pulses. Else count+1.
  - Using ≥ covers a period lowered mid-count: it fires on the next cycle.
- Pending and overrun, per line i:
  - `evt` and `int_ack[i]` together: `interrupt[i]` becomes 1 (the event wins) and `overrun[i]` becomes 0.
  - `evt` alone: if `interrupt[i]` was already 1, set `overrun[i]`. `interrupt[i]` becomes 1.
  - `int_ack[i]` alone: `interrupt[i]` becomes 0 and `overrun[i]` becomes 0.
  - Ack with nothing pending has no effect.
- Asserting `rst` mid-operation discards pending requests and any in-progress debounce immediately, with no event on release.

## Timing

- All outputs are registered. There is no combinational path from inputs to outputs.
- Button latency: `btn_raw` rises and stays stable before edge 0. `btn_evt` is high during the cycle after edge DEBOUNCE_CYCLES+2. `interrupt[1]` is 1 after edge DEBOUNCE_CYCLES+3.
- Timer latency: `timer_en` is sampled 1 at edge 0 with period P. `interrupt[0]` is 1 after edge P. Later events fire every P cycles. P=1 fires every cycle.
- Ack latency: `int_ack[i]` sampled at edge k gives `interrupt[i]`=0 after edge k.
- A glitch shorter than DEBOUNCE_CYCLES synchronized samples produces no event.

## Structure

- Package `int_pkg`:
  - Debounce state enum (LOW, RISE_WAIT, HIGH, FALL_WAIT).
  - Line index constants INT_TIMER=0 and INT_BTN=1.
  - CAUSE bit mapping constant: line i maps to IP(6+i).
- Sub-module `debounce`: synchronizer plus FSM. Inputs `clk`, `rst`, `raw`; outputs `level` and `rise_evt`. `int_source` instantiates it once, for the button line. The timer and pending logic stay in the top.

## Test plan

- Reset: hold `rst`=0 while `btn_raw`=1 and `timer_en`=1, then release. `interrupt`=00 and `overrun`=00 at release. With DEBOUNCE_CYCLES=4, `interrupt[1]` rises 7 edges after release.
- Debounce: with DEBOUNCE_CYCLES=4, pulse `btn_raw` high for 3 cycles → no event. Hold high 10 cycles → exactly one `interrupt[1]` rise, 7 edges after the rise.
- Timer: `timer_period`=5 with `timer_en`=1, and ack each event one cycle after it rises → `interrupt[0]` rises at edges 5, 10 and 15. `timer_period`=0 → never rises.
- Overrun: `timer_period`=3 with no ack → `interrupt[0]`=1 after edge 3 and `overrun[0]`=1 after edge 6. `int_ack`=01 → both clear on the next edge.
- Simultaneous: `int_ack[0]` pulsed in the same cycle as `tmr_evt` → `interrupt[0]` stays 1 and `overrun[0]` is 0.
- Period change: count at 7 with period 10, then write period 4 → event on the next edge, then every 4 cycles.
